// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the ALU execution unit: ROB tag width, RV32I opcodes,
// branch funct3 codes and the branch-condition helper.
package alu_exec_unit_pkg;

    localparam int ROB_BIT_DEF = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Bit 0 = condition taken; reserved funct3 codes (010/011) return 0.
    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = ($signed(a) < $signed(b));
            F3_BGE:  t = ($signed(a) >= $signed(b));
            F3_BLTU: t = (a < b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_exec_unit_fifo.sv
// alu_out_fifo: small result queue between the ALU compute logic and the CDB.
// Entries are opaque packed words; flush dominates push and pop.
module alu_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 69
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I integer/branch/jump execution unit: computes one issued op per cycle,
// queues results and presents the queue head on the ALU CDB port.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int ROB_BIT   = ROB_BIT_DEF,
    parameter int OUT_DEPTH = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               start_alu,
    input  logic [31:0]        vi,
    input  logic [31:0]        vj,
    input  logic [31:0]        imm,
    input  logic [31:0]        inst_addr,
    input  logic [2:0]         op,
    input  logic [6:0]         op_type,
    input  logic               op_addition,
    input  logic [ROB_BIT-1:0] alu_rob_entry,
    output logic               alu_busy,
    input  logic               cdb_grant,
    output logic               alu_ready,
    output logic [ROB_BIT-1:0] finished_alu_rob_entry,
    output logic [31:0]        alu_result,
    output logic [31:0]        alu_next_pc,
    output logic               alu_br_taken
);
    localparam int W = ROB_BIT + 65;

    logic [31:0]  w_result;
    logic [31:0]  w_next_pc;
    logic         w_taken;
    logic [31:0]  w_pc4;
    logic [4:0]   w_shamt;
    logic         w_push;
    logic         w_pop;
    logic         w_flush;
    logic         w_empty;
    logic         w_full;
    logic [W-1:0] w_head;

    assign w_pc4   = inst_addr + 32'd4;
    assign w_shamt = vj[4:0];

    always_comb begin
        w_result  = '0;
        w_next_pc = w_pc4;
        w_taken   = 1'b0;
        case (op_type)
            OPC_OP, OPC_OPIMM: begin
                case (op)
                    3'b000:  w_result = (op_type == OPC_OP && op_addition) ? vi - vj : vi + vj;
                    3'b001:  w_result = vi << w_shamt;
                    3'b010:  w_result = {31'b0, $signed(vi) < $signed(vj)};
                    3'b011:  w_result = {31'b0, vi < vj};
                    3'b100:  w_result = vi ^ vj;
                    3'b101:  w_result = op_addition ? 32'($signed(vi) >>> w_shamt) : vi >> w_shamt;
                    3'b110:  w_result = vi | vj;
                    default: w_result = vi & vj;
                endcase
            end
            OPC_BRANCH: begin
                w_taken   = br_taken(op, vi, vj);
                w_result  = {31'b0, w_taken};
                w_next_pc = w_taken ? inst_addr + imm : w_pc4;
            end
            OPC_LUI:   w_result = imm;
            OPC_AUIPC: w_result = inst_addr + imm;
            OPC_JAL: begin
                w_result  = w_pc4;
                w_next_pc = inst_addr + imm;
                w_taken   = 1'b1;
            end
            OPC_JALR: begin
                w_result  = w_pc4;
                w_next_pc = (vi + imm) & ~32'h1;
                w_taken   = 1'b1;
            end
            default: ;
        endcase
    end

    // Busy is taken from registered fullness only, so a same-cycle pop never frees a slot for a push.
    assign w_flush = rob_clear_up && rdy_in;
    assign w_push  = start_alu && !w_full && rdy_in && !rob_clear_up;
    assign w_pop   = !w_empty && cdb_grant && rdy_in;

    alu_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (W)
    ) u_out_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  ({alu_rob_entry, w_result, w_next_pc, w_taken}),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign alu_busy               = w_full;
    assign alu_ready              = !w_empty;
    assign finished_alu_rob_entry = w_head[W-1 -: ROB_BIT];
    assign alu_result             = w_head[64:33];
    assign alu_next_pc            = w_head[32:1];
    assign alu_br_taken           = w_head[0];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          rob_clear_up = 1'b0;
    logic          start_alu = 1'b0;
    logic [31:0]   vi = '0, vj = '0, imm = '0, inst_addr = '0;
    logic [2:0]    op = '0;
    logic [6:0]    op_type = '0;
    logic          op_addition = 1'b0;
    logic [RB-1:0] alu_rob_entry = '0;
    logic          cdb_grant = 1'b0;
    logic          alu_busy, alu_ready, alu_br_taken;
    logic [RB-1:0] finished_alu_rob_entry;
    logic [31:0]   alu_result, alu_next_pc;

    int n_cmp = 0;
    int n_mis = 0;

    alu_exec_unit #(.ROB_BIT(RB), .OUT_DEPTH(2)) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        .rob_clear_up           (rob_clear_up),
        .start_alu              (start_alu),
        .vi                     (vi),
        .vj                     (vj),
        .imm                    (imm),
        .inst_addr              (inst_addr),
        .op                     (op),
        .op_type                (op_type),
        .op_addition            (op_addition),
        .alu_rob_entry          (alu_rob_entry),
        .alu_busy               (alu_busy),
        .cdb_grant              (cdb_grant),
        .alu_ready              (alu_ready),
        .finished_alu_rob_entry (finished_alu_rob_entry),
        .alu_result             (alu_result),
        .alu_next_pc            (alu_next_pc),
        .alu_br_taken           (alu_br_taken)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [6:0] t, input logic [2:0] f3, input logic add,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] pc, input logic [RB-1:0] tag);
        op_type = t; op = f3; op_addition = add;
        vi = a; vj = b; imm = im; inst_addr = pc; alu_rob_entry = tag;
    endtask

    // Issue with grant held: head visible next cycle, popped the cycle after.
    task automatic issue_chk(input string nm, input logic [6:0] t, input logic [2:0] f3, input logic add,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                             input logic [31:0] pc, input logic [RB-1:0] tag,
                             input logic [31:0] e_res, input logic [31:0] e_npc, input logic e_tk);
        chk({nm, "_busy_before"}, {31'b0, alu_busy}, 32'd0);
        drive(t, f3, add, a, b, im, pc, tag);
        cdb_grant = 1'b1;
        start_alu = 1'b1;
        tick();
        start_alu = 1'b0;
        chk({nm, "_ready"}, {31'b0, alu_ready}, 32'd1);
        chk({nm, "_tag"}, {28'b0, finished_alu_rob_entry}, {28'b0, tag});
        chk({nm, "_result"}, alu_result, e_res);
        chk({nm, "_next_pc"}, alu_next_pc, e_npc);
        chk({nm, "_taken"}, {31'b0, alu_br_taken}, {31'b0, e_tk});
        tick();
        chk({nm, "_popped"}, {31'b0, alu_ready}, 32'd0);
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_ready", {31'b0, alu_ready}, 32'd0);
        chk("rst_busy", {31'b0, alu_busy}, 32'd0);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_npc", alu_next_pc, 32'd0);
        tick();
        tick();
        rst_in = 1'b1;
        tick();

        // arithmetic / logic
        issue_chk("sub", 7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'h0, 32'h40, 4'd3, 32'hFFFFFFFE, 32'h44, 1'b0);
        issue_chk("addi_add", 7'b0010011, 3'b000, 1'b1, 32'd5, 32'd7, 32'h0, 32'h40, 4'd1, 32'd12, 32'h44, 1'b0);
        issue_chk("srai", 7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'd4, 32'h0, 32'h0, 4'd2, 32'hF8000000, 32'h4, 1'b0);
        issue_chk("srl", 7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'h24, 32'h0, 32'h0, 4'd2, 32'h08000000, 32'h4, 1'b0);
        issue_chk("sll", 7'b0110011, 3'b001, 1'b0, 32'h00000003, 32'd31, 32'h0, 32'h0, 4'd4, 32'h80000000, 32'h4, 1'b0);
        issue_chk("slt", 7'b0110011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 4'd5, 32'd1, 32'h4, 1'b0);
        issue_chk("sltu", 7'b0110011, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 4'd6, 32'd0, 32'h4, 1'b0);
        issue_chk("xor", 7'b0110011, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 4'd7, 32'h0FF00FF0, 32'h4, 1'b0);
        issue_chk("or", 7'b0010011, 3'b110, 1'b0, 32'hF0F0F0F0, 32'h0000FFFF, 32'h0, 32'h0, 4'd8, 32'hF0F0FFFF, 32'h4, 1'b0);
        issue_chk("and", 7'b0110011, 3'b111, 1'b0, 32'hF0F0F0F0, 32'h0000FFFF, 32'h0, 32'h0, 4'd9, 32'h0000F0F0, 32'h4, 1'b0);

        // branches, upper-immediate, jumps, unknown
        issue_chk("blt", 7'b1100011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd1, 32'd1, 32'h120, 1'b1);
        issue_chk("bgeu", 7'b1100011, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd2, 32'd1, 32'h120, 1'b1);
        issue_chk("bge", 7'b1100011, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd2, 32'd0, 32'h104, 1'b0);
        issue_chk("bne", 7'b1100011, 3'b001, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 4'd3, 32'd0, 32'h104, 1'b0);
        issue_chk("beq", 7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'hFFFFFFF0, 32'h100, 4'd3, 32'd1, 32'hF0, 1'b1);
        issue_chk("br_rsvd", 7'b1100011, 3'b010, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 4'd4, 32'd0, 32'h104, 1'b0);
        issue_chk("lui", 7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h12345000, 32'h80, 4'd5, 32'h12345000, 32'h84, 1'b0);
        issue_chk("auipc", 7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd6, 32'h3000, 32'h1004, 1'b0);
        issue_chk("jal", 7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h40, 32'h300, 4'd7, 32'h304, 32'h340, 1'b1);
        issue_chk("jalr", 7'b1100111, 3'b000, 1'b0, 32'h1003, 32'd0, 32'd4, 32'h200, 4'd8, 32'h204, 32'h1006, 1'b1);
        issue_chk("unknown", 7'b0000000, 3'b000, 1'b0, 32'd1, 32'd2, 32'h4, 32'h200, 4'd9, 32'd0, 32'h204, 1'b0);

        // back-pressure: two ops with no grant fill the queue
        cdb_grant = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 4'd1);
        start_alu = 1'b1;
        tick();
        chk("bp_ready1", {31'b0, alu_ready}, 32'd1);
        chk("bp_busy1", {31'b0, alu_busy}, 32'd0);
        drive(7'b0110011, 3'b000, 1'b0, 32'd10, 32'd20, 32'h0, 32'h0, 4'd2);
        tick();
        start_alu = 1'b0;
        chk("bp_busy2", {31'b0, alu_busy}, 32'd1);
        chk("bp_head_tag", {28'b0, finished_alu_rob_entry}, 32'd1);
        tick();
        chk("bp_hold_tag", {28'b0, finished_alu_rob_entry}, 32'd1);
        chk("bp_hold_res", alu_result, 32'd3);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        chk("bp_busy_drop", {31'b0, alu_busy}, 32'd0);
        chk("bp_second_tag", {28'b0, finished_alu_rob_entry}, 32'd2);
        chk("bp_second_res", alu_result, 32'd30);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        chk("bp_drained", {31'b0, alu_ready}, 32'd0);

        // flush with a same-cycle issue
        drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 4'd3);
        start_alu = 1'b1;
        tick();
        tick();
        start_alu = 1'b0;
        chk("fl_full", {31'b0, alu_busy}, 32'd1);
        rob_clear_up = 1'b1;
        tick();
        start_alu = 1'b1;
        tick();
        start_alu = 1'b0;
        rob_clear_up = 1'b0;
        chk("fl_ready", {31'b0, alu_ready}, 32'd0);
        chk("fl_busy", {31'b0, alu_busy}, 32'd0);
        tick();
        chk("fl_dropped", {31'b0, alu_ready}, 32'd0);

        // rdy_in low freezes push, pop and flush
        drive(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd3, 32'h0, 32'h0, 4'd5);
        start_alu = 1'b1;
        tick();
        chk("fr_ready", {31'b0, alu_ready}, 32'd1);
        rdy_in = 1'b0;
        cdb_grant = 1'b1;
        rob_clear_up = 1'b1;
        drive(7'b0110011, 3'b000, 1'b0, 32'd7, 32'd7, 32'h0, 32'h0, 4'd6);
        tick();
        tick();
        chk("fr_hold_ready", {31'b0, alu_ready}, 32'd1);
        chk("fr_hold_tag", {28'b0, finished_alu_rob_entry}, 32'd5);
        chk("fr_hold_res", alu_result, 32'd5);
        chk("fr_no_push", {31'b0, alu_busy}, 32'd0);
        rdy_in = 1'b1;
        rob_clear_up = 1'b0;
        start_alu = 1'b0;
        tick();
        chk("fr_pop", {31'b0, alu_ready}, 32'd0);

        // asynchronous reset mid-run with two queued results
        cdb_grant = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 32'd4, 32'd4, 32'h0, 32'h0, 4'd7);
        start_alu = 1'b1;
        tick();
        tick();
        start_alu = 1'b0;
        chk("ar_full", {31'b0, alu_busy}, 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("ar_ready", {31'b0, alu_ready}, 32'd0);
        chk("ar_busy", {31'b0, alu_busy}, 32'd0);
        chk("ar_result", alu_result, 32'd0);
        chk("ar_tag", {28'b0, finished_alu_rob_entry}, 32'd0);
        chk("ar_npc", alu_next_pc, 32'd0);
        tick();
        rst_in = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
